// File: rtl/mult_if.sv
// mult_if: handshake and result bundle of the shift-and-add multiplier.
//   master (pipeline controller): drives start, is_signed, a, b;
//                                 observes busy, done, hi, lo.
//   slave  (mult_unit)          : the reverse.
//
// Handshake: start is a request, sampled on a rising clk edge, and it is
// accepted only when the unit is not busy (idle, or in its done cycle). Once
// an operation is accepted, busy stays high until the product is written.
// After that, done pulses for exactly one cycle, and during that cycle hi/lo
// already hold the new product. busy and done are never high together.
interface mult_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// mult_unit: sequential shift-and-add multiplier for MULT/MULTU.
// It takes one add-and-shift step per cycle and then performs one sign-fix
// step. Latency is fixed at WIDTH+1 edges from the start edge to done.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset (aborts any operation in flight)
//   bus       mult_if slave: start/is_signed/a/b in; busy/done/hi/lo out
//   state_dbg current FSM state (IDLE=0, RUN=1, NEG=2, DONE=3)
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mult_if.slave      bus,
  output logic [1:0] state_dbg
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_NEG  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mq;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Magnitudes for signed operands. Negating the most negative value wraps
  // back to itself, and reading that result as unsigned gives the true
  // magnitude 2^(WIDTH-1).
  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    if (bus.is_signed && bus.a[WIDTH-1]) a_mag = -bus.a;
    if (bus.is_signed && bus.b[WIDTH-1]) b_mag = -bus.b;
  end

  // Partial-sum adder. It is one bit wider than the operands so that the
  // carry survives into the right shift.
  always_comb begin
    sum = acc + (mq[0] ? {1'b0, mcand} : '0);
  end

  // After WIDTH shifts, acc[WIDTH] is always 0 and the unsigned product
  // sits in {acc, mq}.
  always_comb begin
    prod = {acc[WIDTH-1:0], mq};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mcand    <= '0;
      acc      <= '0;
      mq       <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            mcand    <= a_mag;
            mq       <= b_mag;
            neg      <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          {acc, mq} <= {sum, mq} >> 1;
          cnt       <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= S_NEG;
        end
        S_NEG: begin
          {bus.hi, bus.lo} <= neg ? -prod : prod;
          bus.busy         <= 1'b0;
          bus.done         <= 1'b1;
          state            <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_dbg = state;
endmodule

// File: tb/tb_mult_unit.sv
module tb_mult_unit;
  localparam int W = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  mult_if #(.WIDTH(W)) bus ();

  mult_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic rst_q  = 1'b1;

  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];
  logic [2*W-1:0] exp_hilo = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Reference model: the full-precision product of the operands, sign- or
  // zero-extended, reduced mod 2^(2W).
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [2*W-1:0] xa, xb;
    xa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    xb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return xa * xb;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every done against the scoreboard and checks that
  // hi/lo keep the last architectural product between completions.
  always @(negedge clk) begin
    if (rst_q) begin
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
      exp_q.delete();
      lat_q.delete();
      exp_hilo = '0;
    end else begin
      check("busy_done_excl", 64'(bus.busy & bus.done), 64'd0);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
        end else begin
          exp_hilo = exp_q.pop_front();
          check("product", {bus.hi, bus.lo}, exp_hilo);
          check("latency", 64'(cyc), 64'(lat_q.pop_front()));
        end
      end else begin
        check("hilo_hold", {bus.hi, bus.lo}, exp_hilo);
      end
    end
  end

  // Drive an accepted request: start is sampled at the next rising edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    @(posedge clk);
    #1;
    exp_q.push_back(model(a, b, s));
    lat_q.push_back(cyc + LAT);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  // Drive a request that must be ignored because the unit is busy.
  task automatic poke(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done) return;
      if (bus.busy) busy_cycles++;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout actual=no_done required=done_within_200 at cycle %0d", cyc);
  endtask

  logic [W-1:0] corner[6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};

  initial begin
    int bc;
    logic [W-1:0] ra, rb;

    // Reset held for two cycles with a live request.
    bus.start     = 1'b1;
    bus.is_signed = 1'($urandom);
    bus.a         = W'($urandom);
    bus.b         = W'($urandom);
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset", 64'(bus.busy), 64'd0);
    end

    // Unsigned max, with busy-width and explicit result checks.
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done(bc);
    check("umax_busy_cycles", 64'(bc), 64'(LAT));
    check("umax_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    @(negedge clk);

    // Signed cases.
    issue(32'hFFFFFFFD, 32'd7, 1'b1);
    wait_done(bc);
    check("s_m3x7", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
    issue(32'h80000000, 32'h80000000, 1'b1);
    wait_done(bc);
    check("s_minxmin", {bus.hi, bus.lo}, 64'h40000000_00000000);
    issue(32'h0, 32'h80000000, 1'b1);
    wait_done(bc);
    repeat (2) @(negedge clk);

    // Busy protection: requests during RUN are ignored.
    issue(32'd6, 32'd7, 1'b0);
    wait_done(bc);
    issue(32'd5, 32'd5, 1'b0);
    repeat (2) @(negedge clk);
    poke(32'd9, 32'd9, 1'b0);
    repeat (16) @(negedge clk);
    poke(32'hFFFF, 32'h1234, 1'b1);
    wait_done(bc);
    check("busy_prot_hilo", {bus.hi, bus.lo}, 64'd25);
    repeat (3) @(negedge clk);

    // Reset abort mid-operation, then a clean operation.
    issue(32'h12345678, 32'h10, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    issue(32'd3, 32'd4, 1'b0);
    wait_done(bc);
    check("after_abort_hilo", {bus.hi, bus.lo}, 64'd12);

    // Back-to-back: new start during the done cycle.
    issue(32'd2, 32'd2, 1'b0);
    wait_done(bc);
    issue(32'd6, 32'd7, 1'b0);
    wait_done(bc);
    check("b2b_hilo", {bus.hi, bus.lo}, 64'd42);

    // Randomized operations with random gaps (a gap of 0 is back-to-back).
    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
      issue(ra, rb, 1'($urandom));
      wait_done(bc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
